// File: rtl/sudoku_pkg.sv
// Shared types and constants for the sudoku checker slice: cell/index types,
// checker state encoding and request validation.
package sudoku_pkg;

    localparam int unsigned GRID_CELLS = 81;
    localparam int unsigned PEER_COUNT = 27;

    typedef logic [3:0] cell_t;
    typedef logic [6:0] index_t;
    typedef logic [4:0] slot_t;

    localparam cell_t BLANK   = 4'd0;
    localparam cell_t MAX_NUM = 4'd9;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SCAN  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam slot_t LAST_SLOT = 5'(PEER_COUNT - 1);

    function automatic logic request_ok(input index_t idx, input cell_t num);
        return (num != BLANK) && (num <= MAX_NUM) && (idx < 7'(GRID_CELLS));
    endfunction

endpackage

// File: rtl/sudoku_peer_addr_gen.sv
// Combinational peer address generator: maps (cell index, scan slot) to the
// grid address of that row/column/box peer and flags the cell itself.
module sudoku_peer_addr_gen
    import sudoku_pkg::*;
(
    input  logic [6:0] index,
    input  logic [4:0] slot,
    output logic [6:0] addr,
    output logic       self_mask
);

    index_t row;
    index_t col;
    index_t box_row;
    index_t box_col;
    index_t slot_w;
    index_t sub;
    index_t sub_row;
    index_t sub_col;

    // Row via threshold compares instead of a divider.
    always_comb begin
        row = '0;
        for (int unsigned t = 1; t < 9; t++) begin
            if (index >= 7'(9 * t)) begin
                row = 7'(t);
            end
        end
        col = index - row * 7'd9;

        if (row >= 7'd6) begin
            box_row = 7'd6;
        end else if (row >= 7'd3) begin
            box_row = 7'd3;
        end else begin
            box_row = 7'd0;
        end

        if (col >= 7'd6) begin
            box_col = 7'd6;
        end else if (col >= 7'd3) begin
            box_col = 7'd3;
        end else begin
            box_col = 7'd0;
        end
    end

    always_comb begin
        slot_w  = {2'b00, slot};
        sub     = '0;
        sub_row = '0;
        sub_col = '0;
        addr    = '0;
        if (slot_w < 7'd9) begin
            addr = row * 7'd9 + slot_w;
        end else if (slot_w < 7'd18) begin
            addr = (slot_w - 7'd9) * 7'd9 + col;
        end else begin
            sub = slot_w - 7'd18;
            if (sub >= 7'd6) begin
                sub_row = 7'd2;
            end else if (sub >= 7'd3) begin
                sub_row = 7'd1;
            end else begin
                sub_row = 7'd0;
            end
            sub_col = sub - sub_row * 7'd3;
            addr    = (box_row + sub_row) * 7'd9 + box_col + sub_col;
        end
        self_mask = (addr == index);
    end

endmodule

// File: rtl/sudoku_checker.sv
// Placement validity checker: scans the 27 peers of a cell through the grid
// read port. Optional macro CHECKER_EARLY_EXIT_EN ends the scan on first conflict.
module sudoku_checker
    import sudoku_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       chk_req,
    input  logic [6:0] cell_index_in,
    input  logic [3:0] num_in,
    input  logic [3:0] mem_rd_data,
    output logic       mem_rd_en,
    output logic [6:0] mem_addr,
    output logic       busy,
    output logic       chk_done,
    output logic       chk_valid
);

`ifdef CHECKER_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    logic [1:0] state;
    index_t     idx_q;
    cell_t      num_q;
    slot_t      k;
    logic       pend;
    logic       conflict;
    logic       hit;
    index_t     peer_addr;
    logic       peer_self;

    sudoku_peer_addr_gen u_peer (
        .index     (idx_q),
        .slot      (k),
        .addr      (peer_addr),
        .self_mask (peer_self)
    );

    assign mem_rd_en = (state == ST_SCAN);
    assign mem_addr  = mem_rd_en ? peer_addr : '0;

    // pend marks that the data returning this cycle belongs to an unmasked slot.
    always_comb begin
        hit = pend && (mem_rd_data == num_q) && (mem_rd_data != BLANK);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            idx_q     <= '0;
            num_q     <= '0;
            k         <= '0;
            pend      <= 1'b0;
            conflict  <= 1'b0;
            busy      <= 1'b0;
            chk_done  <= 1'b0;
            chk_valid <= 1'b0;
        end else begin
            chk_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    pend <= 1'b0;
                    if (chk_req) begin
                        idx_q     <= cell_index_in;
                        num_q     <= num_in;
                        k         <= '0;
                        conflict  <= 1'b0;
                        busy      <= 1'b1;
                        chk_valid <= 1'b0;
                        state     <= request_ok(cell_index_in, num_in) ? ST_SCAN : ST_RESP;
                    end
                end
                ST_SCAN: begin
                    pend     <= !peer_self;
                    conflict <= conflict | hit;
                    if (EARLY_EXIT && hit) begin
                        pend      <= 1'b0;
                        k         <= '0;
                        busy      <= 1'b0;
                        chk_done  <= 1'b1;
                        chk_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end else if (k == LAST_SLOT) begin
                        state <= ST_DRAIN;
                    end else begin
                        k <= k + 5'd1;
                    end
                end
                ST_DRAIN: begin
                    // Last slot's data arrives here; fold it in before reporting.
                    pend      <= 1'b0;
                    k         <= '0;
                    busy      <= 1'b0;
                    chk_done  <= 1'b1;
                    chk_valid <= !(conflict | hit);
                    state     <= ST_IDLE;
                end
                ST_RESP: begin
                    busy      <= 1'b0;
                    chk_done  <= 1'b1;
                    chk_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sudoku_checker.sv
// Self-checking bench for sudoku_checker: grid memory model plus a
// row/column/box reference model built from plain division arithmetic.
module tb_sudoku_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       chk_req;
    logic [6:0] cell_index_in;
    logic [3:0] num_in;
    logic [3:0] mem_rd_data;
    logic       mem_rd_en;
    logic [6:0] mem_addr;
    logic       busy;
    logic       chk_done;
    logic       chk_valid;

    int checks = 0;
    int errors = 0;

    logic [3:0] grid [81];

`ifdef CHECKER_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    sudoku_checker dut (
        .clk           (clk),
        .rst           (rst),
        .chk_req       (chk_req),
        .cell_index_in (cell_index_in),
        .num_in        (num_in),
        .mem_rd_data   (mem_rd_data),
        .mem_rd_en     (mem_rd_en),
        .mem_addr      (mem_addr),
        .busy          (busy),
        .chk_done      (chk_done),
        .chk_valid     (chk_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= (mem_addr < 7'd81) ? grid[mem_addr] : 4'd0;
    end

    function automatic bit req_ok(int idx, int num);
        return (num >= 1) && (num <= 9) && (idx >= 0) && (idx <= 80);
    endfunction

    function automatic int model_peer(int idx, int k);
        int r = idx / 9;
        int c = idx % 9;
        if (k < 9) return r * 9 + k;
        if (k < 18) return (k - 9) * 9 + c;
        return (3 * (r / 3) + (k - 18) / 3) * 9 + 3 * (c / 3) + (k - 18) % 3;
    endfunction

    function automatic bit model_legal(int idx, int num);
        if (!req_ok(idx, num)) return 1'b0;
        for (int p = 0; p < 81; p++) begin
            if (p != idx && grid[p] == 4'(num) &&
                (p / 9 == idx / 9 || p % 9 == idx % 9 ||
                 (p / 27 == idx / 27 && (p % 9) / 3 == (idx % 9) / 3)))
                return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int model_first_slot(int idx, int num);
        for (int k = 0; k < 27; k++) begin
            int a = model_peer(idx, k);
            if (a != idx && grid[a] == 4'(num)) return k;
        end
        return -1;
    endfunction

    function automatic int model_done(int idx, int num);
        int s;
        if (!req_ok(idx, num)) return 1;
        s = model_first_slot(idx, num);
        if (EARLY && s >= 0) return s + 2;
        return 28;
    endfunction

    function automatic int model_reads(int idx, int num);
        int d = model_done(idx, num);
        if (d == 1) return 0;
        return (d > 27) ? 27 : d;
    endfunction

    task automatic clear_grid();
        for (int i = 0; i < 81; i++) grid[i] = 4'd0;
    endtask

    // Issues one request from just after an edge and follows it to chk_done.
    task automatic run_check(input int idx, input int num, output int done_at,
                             output logic valid_at, output int reads, output int addr_err);
        cell_index_in = 7'(idx);
        num_in        = 4'(num);
        chk_req       = 1'b1;
        @(posedge clk);
        #1;
        chk_req  = 1'b0;
        done_at  = -1;
        valid_at = 1'bx;
        reads    = 0;
        addr_err = 0;
        for (int n = 0; n <= 40; n++) begin
            if (n > 0) begin
                @(posedge clk);
                #1;
            end
            if (chk_done === 1'b1) begin
                done_at  = n;
                valid_at = chk_valid;
                break;
            end
            if (mem_rd_en === 1'b1) begin
                if (reads >= 27 || mem_addr !== 7'(model_peer(idx, reads))) addr_err++;
                reads++;
            end
        end
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        chk_req = 1'b0;
        cell_index_in = '0;
        num_in  = '0;
        clear_grid();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (chk_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", chk_done); end
        checks++; if (chk_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", chk_valid); end
        checks++; if (mem_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got=%b exp=0", mem_rd_en); end
        checks++; if (mem_addr !== 7'd0) begin errors++; $display("FAIL reset_addr got=%0d exp=0", mem_addr); end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int fill_addr;
        int fill_val;
        int idx;
        int num;
        bit exp_valid;
        int done_early;
        int done_late;
    } case_t;

    task automatic test_directed();
        case_t cases [11];
        int done_at, reads, addr_err, exp_done, exp_reads;
        logic v;
        cases = '{
            '{-1, 0,   0,  5, 1'b1, 28, 28},
            '{ 3, 5,   0,  5, 1'b0,  5, 28},
            '{72, 7,   0,  7, 1'b0, 19, 28},
            '{20, 9,   0,  9, 1'b0, 28, 28},
            '{40, 4,  40,  4, 1'b1, 28, 28},
            '{80, 2,   8,  2, 1'b0, 19, 28},
            '{44, 6,  40,  6, 1'b0, 10, 28},
            '{-1, 0,   0,  0, 1'b0,  1,  1},
            '{-1, 0,   5, 10, 1'b0,  1,  1},
            '{-1, 0,  81,  3, 1'b0,  1,  1},
            '{-1, 0, 127,  9, 1'b0,  1,  1}
        };
        foreach (cases[i]) begin
            clear_grid();
            if (cases[i].fill_addr >= 0) grid[cases[i].fill_addr] = 4'(cases[i].fill_val);
            run_check(cases[i].idx, cases[i].num, done_at, v, reads, addr_err);
            exp_done  = EARLY ? cases[i].done_early : cases[i].done_late;
            exp_reads = (exp_done == 1) ? 0 : ((exp_done > 27) ? 27 : exp_done);
            checks++; if (done_at != exp_done) begin errors++;
                $display("FAIL dir%0d_latency got=%0d exp=%0d", i, done_at, exp_done); end
            checks++; if (v !== cases[i].exp_valid) begin errors++;
                $display("FAIL dir%0d_valid got=%b exp=%b", i, v, cases[i].exp_valid); end
            checks++; if (reads != exp_reads) begin errors++;
                $display("FAIL dir%0d_reads got=%0d exp=%0d", i, reads, exp_reads); end
            checks++; if (addr_err != 0) begin errors++;
                $display("FAIL dir%0d_addr bad_addrs=%0d exp=0", i, addr_err); end
            @(posedge clk);
            #1;
            checks++; if (chk_done !== 1'b0) begin errors++;
                $display("FAIL dir%0d_done_pulse got=%b exp=0", i, chk_done); end
        end
    endtask

    task automatic test_random();
        int idx, num, done_at, reads, addr_err, e_done, e_reads;
        logic v, e_valid;
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < 81; i++)
                grid[i] = ($urandom_range(0, 9) < 3) ? 4'($urandom_range(1, 9)) : 4'd0;
            idx = ($urandom_range(0, 9) == 0) ? int'($urandom_range(81, 127)) : int'($urandom_range(0, 80));
            num = ($urandom_range(0, 9) == 0) ? int'($urandom_range(10, 15)) * int'($urandom_range(0, 1))
                                              : int'($urandom_range(1, 9));
            if (idx <= 80 && $urandom_range(0, 2) == 0)
                grid[model_peer(idx, int'($urandom_range(0, 26)))] = 4'(num);
            e_valid = model_legal(idx, num);
            e_done  = model_done(idx, num);
            e_reads = model_reads(idx, num);
            run_check(idx, num, done_at, v, reads, addr_err);
            checks++; if (done_at != e_done) begin errors++;
                $display("FAIL rnd%0d_latency idx=%0d num=%0d got=%0d exp=%0d", it, idx, num, done_at, e_done); end
            checks++; if (v !== e_valid) begin errors++;
                $display("FAIL rnd%0d_valid idx=%0d num=%0d got=%b exp=%b", it, idx, num, v, e_valid); end
            checks++; if (reads != e_reads || addr_err != 0) begin errors++;
                $display("FAIL rnd%0d_reads got=%0d bad=%0d exp=%0d bad=0", it, reads, addr_err, e_reads); end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_busy_ignore();
        int dones = 0;
        int first = -1;
        logic v = 1'bx;
        clear_grid();
        cell_index_in = 7'd0;
        num_in  = 4'd1;
        chk_req = 1'b1;
        @(posedge clk);
        #1;
        chk_req = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_high got=%b exp=1", busy); end
        for (int n = 1; n <= 60; n++) begin
            if (n == 5) begin
                cell_index_in = 7'd3;
                num_in  = 4'd2;
                chk_req = 1'b1;
            end
            if (n == 6) chk_req = 1'b0;
            @(posedge clk);
            #1;
            if (chk_done === 1'b1) begin
                dones++;
                if (first < 0) begin first = n; v = chk_valid; end
            end
        end
        checks++; if (dones != 1) begin errors++; $display("FAIL busy_single_done got=%0d exp=1", dones); end
        checks++; if (first != 28) begin errors++; $display("FAIL busy_latency got=%0d exp=28", first); end
        checks++; if (v !== 1'b1) begin errors++; $display("FAIL busy_valid got=%b exp=1", v); end
    endtask

    task automatic test_back_to_back();
        int d1, d2, r1, r2, a1, a2;
        logic v1, v2;
        clear_grid();
        grid[30] = 4'd8;
        run_check(27, 3, d1, v1, r1, a1);
        run_check(27, 8, d2, v2, r2, a2);
        checks++; if (d1 != 28 || v1 !== 1'b1) begin errors++;
            $display("FAIL b2b_first got=%0d/%b exp=28/1", d1, v1); end
        checks++; if (d2 != model_done(27, 8) || v2 !== 1'b0) begin errors++;
            $display("FAIL b2b_second got=%0d/%b exp=%0d/0", d2, v2, model_done(27, 8)); end
        checks++; if (r2 != model_reads(27, 8) || a2 != 0) begin errors++;
            $display("FAIL b2b_reads got=%0d bad=%0d exp=%0d", r2, a2, model_reads(27, 8)); end
        run_check(10, 5, d1, v1, r1, a1);
        repeat (4) @(posedge clk);
        #1;
        checks++; if (chk_valid !== 1'b1 || busy !== 1'b0) begin errors++;
            $display("FAIL valid_hold got=%b busy=%b exp=1 busy=0", chk_valid, busy); end
    endtask

    task automatic test_reset_mid();
        int dones = 0;
        int d, r, a;
        logic v;
        clear_grid();
        cell_index_in = 7'd0;
        num_in  = 4'd5;
        chk_req = 1'b1;
        @(posedge clk);
        #1;
        chk_req = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++; if ({busy, chk_done, chk_valid, mem_rd_en} !== 4'b0 || mem_addr !== 7'd0) begin errors++;
            $display("FAIL midrst_outputs got=%b%b%b%b addr=%0d exp=0000 addr=0",
                     busy, chk_done, chk_valid, mem_rd_en, mem_addr); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int n = 0; n < 35; n++) begin
            @(posedge clk);
            #1;
            if (chk_done === 1'b1 || mem_rd_en === 1'b1) dones++;
        end
        checks++; if (dones != 0) begin errors++; $display("FAIL midrst_no_done got=%0d exp=0", dones); end
        run_check(0, 5, d, v, r, a);
        checks++; if (d != 28 || v !== 1'b1 || r != 27) begin errors++;
            $display("FAIL midrst_recover got=%0d/%b/%0d exp=28/1/27", d, v, r); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_busy_ignore();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sudoku_checker.md
Name: sudoku_checker

Overview:
- Validity checker for the sudoku solver: answers "may number N be placed at cell I?" by scanning the 27 row/column/box peer addresses of I through a read port on the grid memory.
- Sits beside the solver controller, which issues the check request and consumes chk_valid on chk_done.
- Multi-cycle with a req/done handshake, so the controller waits for chk_done rather than sampling a combinational flag.

Parameters:
- GRID_CELLS, 81, number of cells; cell_index range is 0..GRID_CELLS-1.
- PEER_COUNT, 27, scan slots per check: 9 row + 9 column + 9 box, self included.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- chk_req  input  1  check request; sampled only in IDLE.
- cell_index_in  input  7  cell under test, 0..80.
- num_in  input  4  candidate number, 1..9.
- mem_rd_data  input  4  grid memory read data; valid one cycle after mem_rd_en.
- mem_rd_en  output  1  grid memory read strobe.
- mem_addr  output  7  grid memory read address.
- busy  output  1  high from the accepting edge until chk_done.
- chk_done  output  1  one-cycle pulse, result ready.
- chk_valid  output  1  1 = placement legal; held until the next accepted request.

Behaviour:
- Reset, asynchronous: state IDLE; mem_rd_en=0, mem_addr=0, busy=0, chk_done=0, chk_valid=0; counters cleared.
- Reset asserted mid-scan aborts at once. No chk_done is produced for the aborted request.
- States are IDLE, SCAN, DRAIN and RESP.
- IDLE: at an edge E0 with chk_req=1, latch cell_index_in and num_in, and set busy=1.
  - Invalid input (num 0 or >9, or index >80): go to RESP with result 0. chk_done=1 and chk_valid=0 at E0+1. No memory reads.
  - Otherwise: derive row r=idx/9, col c=idx%9, box origin (3*(r/3), 3*(c/3)), set k=0, go to SCAN.
- SCAN: mem_rd_en=1 and mem_addr=peer(k) during the cycle after edge E0+k; k increments each cycle; after k=26, go to DRAIN.
  - k 0-8: r*9+k.
  - k 9-17: (k-9)*9+c.
  - k 18-26: (br+(k-18)/3)*9 + bc+(k-18)%3.
- Compare stage: mem_rd_data is compared with the latched num one cycle after its address. A slot whose address equals the latched index (self) is masked and never flags a conflict.
- A conflict sets a sticky flag.
- Result registers: chk_done=1 for exactly one cycle and chk_valid=!conflict at edge E0+28. busy falls at the same edge and the block returns to IDLE.
- chk_req while busy=1 is ignored, not queued.
- A chk_req held high in IDLE on the cycle after chk_done starts a new check.
- Blank peers (0) never conflict.
- Addresses are always 0..80; no wrap-around arithmetic.
- Row and column are derived by a small lookup or a subtract-9 loop; no combinational divider.

Optional Feature:
- Macro CHECKER_EARLY_EXIT_EN.
- Defined: the first unmasked conflict from slot k stops issuing reads (mem_rd_en=0 from the next cycle). chk_done=1 and chk_valid=0 at E0+k+2. Legal placements still complete at E0+28.
- Undefined: every check takes fixed latency, with done at E0+28, or E0+1 for invalid input.

Decomposition:
- Package sudoku_pkg:
  - GRID_CELLS=81, PEER_COUNT=27, 4-bit cell value type, 7-bit index type.
  - Checker state encoding; BLANK=0.
- Sub-module sudoku_peer_addr_gen: combinational (index, k) -> peer address plus self-mask bit. Reused by later candidate-precompute logic.

Test Plan:
- All-zero grid; req idx=0 num=5 -> chk_done at E0+28, chk_valid=1, exactly 27 mem_rd_en cycles.
- Cell 3 holds 5; req idx=0 num=5 -> chk_valid=0. Done at E0+5 with CHECKER_EARLY_EXIT_EN, E0+28 without.
- Column conflict: cell 72 holds 7; req idx=0 num=7 -> chk_valid=0. Done at E0+19 with early exit.
- Box conflict: cell 20 holds 9; req idx=0 num=9 -> chk_valid=0 at E0+28 (slot 26). Self: cell 40 holds 4; req idx=40 num=4 with no other 4 -> chk_valid=1.
- num_in=0 or idx=81 -> chk_done at E0+1, chk_valid=0, mem_rd_en never asserted. chk_req during busy -> ignored, single chk_done.
- rst pulsed at E0+10 -> all outputs 0 immediately, no chk_done. A new req afterward completes normally at its own E0+28.
